// File: rtl/tcb_trigger_sched.sv
// Periodic TCB trigger scheduler: raises a TCB request every PERIOD cycles and
// checks entry deadline, execution budget and exit point; violations assert reset.
module tcb_trigger_sched #(
    parameter logic [15:0] SMEM_BASE      = 16'hA000,
    parameter logic [15:0] SMEM_SIZE      = 16'h4000,
    parameter logic [15:0] TCB_ENTRY      = 16'hA000,
    parameter logic [15:0] TCB_EXIT       = 16'hA0FE,
    parameter logic [15:0] RESET_HANDLER  = 16'h0000,
    parameter logic [15:0] PERIOD         = 16'd1000,
    parameter logic [15:0] ENTRY_DEADLINE = 16'd64,
    parameter logic [15:0] EXEC_MAX       = 16'd4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc,
    output logic        irq_req,
    output logic        tcb_busy,
    output logic        reset,
    output logic [7:0]  viol_cnt
);
    // 17-bit end address so a range reaching 16'hFFFF still compares correctly
    localparam logic [16:0] SMEM_END = {1'b0, SMEM_BASE} + {1'b0, SMEM_SIZE};

    typedef enum logic [1:0] {S_COUNT, S_REQ, S_EXEC, S_VIOL} state_t;

    state_t      state_q, state_d;
    logic [15:0] period_q, period_d;
    logic [15:0] dl_q, dl_d;
    logic [15:0] exec_q, exec_d;
    logic [15:0] pc_prev_q;
    logic [7:0]  viol_cnt_q, viol_cnt_d;
    logic        irq_q, busy_q, reset_q;
    logic        in_tcb;

    assign in_tcb = (pc >= SMEM_BASE) && ({1'b0, pc} < SMEM_END);

    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        dl_d       = dl_q;
        exec_d     = exec_q;
        viol_cnt_d = viol_cnt_q;
        case (state_q)
            S_COUNT: begin
                // an entry beats the period expiry on the same edge
                if (in_tcb && pc == TCB_ENTRY) begin
                    state_d  = S_EXEC;
                    period_d = 16'd0;
                    exec_d   = 16'd0;
                end else if (in_tcb) begin
                    state_d = S_VIOL;
                end else if (period_q == PERIOD - 16'd1) begin
                    state_d  = S_REQ;
                    period_d = 16'd0;
                    dl_d     = 16'd0;
                end else begin
                    period_d = period_q + 16'd1;
                end
            end
            S_REQ: begin
                dl_d = dl_q + 16'd1;
                if (pc == TCB_ENTRY) begin
                    state_d = S_EXEC;
                    exec_d  = 16'd0;
                end else if (in_tcb || dl_q == ENTRY_DEADLINE - 16'd1) begin
                    state_d = S_VIOL;
                end
            end
            S_EXEC: begin
                exec_d = exec_q + 16'd1;
                // the exit check takes priority over budget expiry
                if (!in_tcb) begin
                    if (pc_prev_q == TCB_EXIT) begin
                        state_d  = S_COUNT;
                        period_d = 16'd0;
                    end else begin
                        state_d = S_VIOL;
                    end
                end else if (exec_q == EXEC_MAX - 16'd1) begin
                    state_d = S_VIOL;
                end
            end
            S_VIOL: begin
                if (pc == RESET_HANDLER) begin
                    state_d  = S_COUNT;
                    period_d = 16'd0;
                    dl_d     = 16'd0;
                    exec_d   = 16'd0;
                end
            end
            default: state_d = S_COUNT;
        endcase
        if (state_d == S_VIOL && state_q != S_VIOL && viol_cnt_q != 8'hFF)
            viol_cnt_d = viol_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_COUNT;
            period_q   <= 16'd0;
            dl_q       <= 16'd0;
            exec_q     <= 16'd0;
            pc_prev_q  <= 16'd0;
            viol_cnt_q <= 8'd0;
            irq_q      <= 1'b0;
            busy_q     <= 1'b0;
            reset_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            dl_q       <= dl_d;
            exec_q     <= exec_d;
            pc_prev_q  <= pc;
            viol_cnt_q <= viol_cnt_d;
            irq_q      <= (state_d == S_REQ);
            busy_q     <= (state_d == S_EXEC);
            reset_q    <= (state_d == S_VIOL);
        end
    end

    assign irq_req  = irq_q;
    assign tcb_busy = busy_q;
    assign reset    = reset_q;
    assign viol_cnt = viol_cnt_q;
endmodule

// File: tb/tb_tcb_trigger_sched.sv
// Bench for tcb_trigger_sched: directed scenarios plus random pc traffic, all
// checked against a timestamp-based reference model of the scheduling rules.
module tb_tcb_trigger_sched;
    localparam int P = 100;
    localparam int D = 20;
    localparam int X = 50;
    localparam int M_COUNT = 0, M_REQ = 1, M_EXEC = 2, M_VIOL = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc = 16'h4400;
    logic        irq_req, tcb_busy, reset;
    logic [7:0]  viol_cnt;

    tcb_trigger_sched #(
        .PERIOD(16'd100), .ENTRY_DEADLINE(16'd20), .EXEC_MAX(16'd50)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc),
        .irq_req(irq_req), .tcb_busy(tcb_busy), .reset(reset), .viol_cnt(viol_cnt)
    );

    always #5 clk = ~clk;

    int nchk = 0, nfail = 0;
    // model: edge count, mode, and timestamps of period start / request / entry
    int t = 0, m_mode = M_COUNT, m_s = 0, m_treq = 0, m_tent = 0, m_vc = 0;
    logic [15:0] m_prev = 16'h0;
    logic        e_irq = 1'b0, e_busy = 1'b0, e_rst = 1'b0;
    logic [7:0]  e_vc = 8'h0;

    function automatic bit in_tcb(input logic [15:0] p);
        return ({16'h0, p} >= 32'hA000) && ({16'h0, p} < 32'hE000);
    endfunction

    task automatic step(input logic [15:0] p);
        int nm;
        pc = p;
        @(posedge clk);
        t++;
        nm = m_mode;
        if (!rst_n) begin
            nm = M_COUNT; m_s = t; m_vc = 0;
        end else begin
            case (m_mode)
                M_COUNT:
                    if (p == 16'hA000) begin nm = M_EXEC; m_tent = t; end
                    else if (in_tcb(p)) nm = M_VIOL;
                    else if (t - m_s == P) begin nm = M_REQ; m_treq = t; end
                M_REQ:
                    if (p == 16'hA000) begin nm = M_EXEC; m_tent = t; end
                    else if (in_tcb(p) || t - m_treq == D) nm = M_VIOL;
                M_EXEC:
                    if (!in_tcb(p)) begin
                        if (m_prev == 16'hA0FE) begin nm = M_COUNT; m_s = t; end
                        else nm = M_VIOL;
                    end else if (t - m_tent == X) nm = M_VIOL;
                default:
                    if (p == 16'h0000) begin nm = M_COUNT; m_s = t; end
            endcase
            if (nm == M_VIOL && m_mode != M_VIOL && m_vc < 255) m_vc++;
        end
        m_prev = rst_n ? p : 16'h0;
        m_mode = nm;
        e_irq  = (m_mode == M_REQ);
        e_busy = (m_mode == M_EXEC);
        e_rst  = (m_mode == M_VIOL);
        e_vc   = m_vc[7:0];
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin
            step(16'h4400);
            nchk++;
            if ({irq_req, tcb_busy, reset, viol_cnt} !== 11'b0) begin
                nfail++;
                $display("FAIL reset t=%0d: got %b%b%b/%0d required 000/0", t, irq_req, tcb_busy, reset, viol_cnt);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_nominal();
        int n;
        n = 0;
        while (!irq_req && n < 300) begin step(16'h4400); n++; end
        nchk++;
        if (n != P) begin nfail++; $display("FAIL nominal_first_irq: got %0d cycles required %0d", n, P); end
        repeat (5) step(16'h4400);
        step(16'hA000);
        nchk++;
        if ({irq_req, tcb_busy} !== 2'b01) begin
            nfail++; $display("FAIL nominal_entry: got irq=%b busy=%b required irq=0 busy=1", irq_req, tcb_busy);
        end
        for (int i = 1; i <= 16; i++) begin
            step(16'hA000 + 16'(2 * i));
            nchk++;
            if ({irq_req, tcb_busy, reset, viol_cnt} !== {e_irq, e_busy, e_rst, e_vc}) begin
                nfail++; $display("FAIL nominal_walk t=%0d: got %b%b%b/%0d required %b%b%b/%0d", t,
                                  irq_req, tcb_busy, reset, viol_cnt, e_irq, e_busy, e_rst, e_vc);
            end
        end
        step(16'hA0FE);
        step(16'h4400);
        nchk++;
        if ({tcb_busy, reset, viol_cnt} !== 10'b0) begin
            nfail++; $display("FAIL nominal_exit: got busy=%b reset=%b vc=%0d required 0/0/0", tcb_busy, reset, viol_cnt);
        end
        n = 0;
        while (!irq_req && n < 300) begin step(16'h4400); n++; end
        nchk++;
        if (n != P) begin nfail++; $display("FAIL nominal_next_irq: got %0d cycles required %0d", n, P); end
    endtask

    task automatic test_deadline();
        int n;
        n = 0;
        while (!reset && n < 100) begin step(16'h4400); n++; end
        nchk++;
        if (n != D || viol_cnt !== 8'd1) begin
            nfail++; $display("FAIL deadline: got %0d cycles vc=%0d required %0d cycles vc=1", n, viol_cnt, D);
        end
        step(16'h0000);
        nchk++;
        if ({irq_req, tcb_busy, reset} !== 3'b000) begin
            nfail++; $display("FAIL deadline_recover: got %b%b%b required 000", irq_req, tcb_busy, reset);
        end
    endtask

    task automatic test_bad_entry();
        int n;
        repeat (3) step(16'h4400);
        step(16'hA010);
        nchk++;
        if (reset !== 1'b1 || viol_cnt !== 8'd2) begin
            nfail++; $display("FAIL bad_entry_count: got reset=%b vc=%0d required 1/2", reset, viol_cnt);
        end
        step(16'h0000);
        n = 0;
        while (!irq_req && n < 300) begin step(16'h4400); n++; end
        step(16'hA010);
        nchk++;
        if ({irq_req, reset, viol_cnt} !== {1'b0, 1'b1, 8'd3}) begin
            nfail++; $display("FAIL bad_entry_req: got irq=%b reset=%b vc=%0d required 0/1/3", irq_req, reset, viol_cnt);
        end
        step(16'h0000);
    endtask

    task automatic test_bad_exit();
        int n;
        step(16'hA000);
        step(16'hA010);
        step(16'hA020);
        step(16'h4400);
        nchk++;
        if ({tcb_busy, reset} !== 2'b01) begin
            nfail++; $display("FAIL bad_exit: got busy=%b reset=%b required 0/1", tcb_busy, reset);
        end
        step(16'h0000);
        step(16'hA000);
        n = 0;
        while (!reset && n < 200) begin step(16'hA010); n++; end
        nchk++;
        if (n != X || viol_cnt !== 8'd5) begin
            nfail++; $display("FAIL over_budget: got %0d cycles vc=%0d required %0d cycles vc=5", n, viol_cnt, X);
        end
        step(16'h0000);
    endtask

    task automatic test_collision();
        int n;
        for (int i = 0; i < P - 1; i++) begin
            step(16'h4400);
            nchk++;
            if ({irq_req, tcb_busy, reset, viol_cnt} !== {e_irq, e_busy, e_rst, e_vc}) begin
                nfail++; $display("FAIL collision_count t=%0d: got %b%b%b/%0d required %b%b%b/%0d", t,
                                  irq_req, tcb_busy, reset, viol_cnt, e_irq, e_busy, e_rst, e_vc);
            end
        end
        step(16'hA000);
        nchk++;
        if ({irq_req, tcb_busy} !== 2'b01) begin
            nfail++; $display("FAIL collision_entry: got irq=%b busy=%b required 0/1", irq_req, tcb_busy);
        end
        for (int i = 1; i <= X - 2; i++) step(16'hA000 + 16'(2 * i));
        step(16'hA0FE);
        step(16'h4400);
        nchk++;
        if ({tcb_busy, reset, viol_cnt} !== {1'b0, 1'b0, 8'd5}) begin
            nfail++; $display("FAIL collision_exit: got busy=%b reset=%b vc=%0d required 0/0/5", tcb_busy, reset, viol_cnt);
        end
        n = 0;
        while (!irq_req && n < 300) begin step(16'h4400); n++; end
        nchk++;
        if (n != P) begin nfail++; $display("FAIL collision_next_irq: got %0d cycles required %0d", n, P); end
    endtask

    task automatic test_rst_mid();
        step(16'hA010);
        rst_n = 1'b0;
        step(16'hA010);
        nchk++;
        if ({irq_req, tcb_busy, reset, viol_cnt} !== 11'b0) begin
            nfail++; $display("FAIL rst_mid: got %b%b%b/%0d required 000/0", irq_req, tcb_busy, reset, viol_cnt);
        end
        rst_n = 1'b1;
        step(16'h4400);
        nchk++;
        if ({irq_req, tcb_busy, reset, viol_cnt} !== {e_irq, e_busy, e_rst, e_vc}) begin
            nfail++; $display("FAIL rst_mid_after: got %b%b%b/%0d required %b%b%b/%0d",
                              irq_req, tcb_busy, reset, viol_cnt, e_irq, e_busy, e_rst, e_vc);
        end
    endtask

    task automatic test_saturation();
        repeat (300) begin step(16'hA010); step(16'h0000); end
        nchk++;
        if (viol_cnt !== 8'hFF || e_vc !== 8'hFF) begin
            nfail++; $display("FAIL saturation: got vc=%0d required 255 (model %0d)", viol_cnt, e_vc);
        end
    endtask

    task automatic test_random();
        logic [15:0] p;
        int r;
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            r = int'($urandom_range(0, 99));
            if (m_mode == M_EXEC)
                p = (r < 60) ? 16'hA000 + 16'($urandom_range(0, 255)) :
                    (r < 80) ? 16'hA0FE : 16'h4400;
            else
                p = (r < 90) ? 16'h4400 : (r < 93) ? 16'hA000 : (r < 95) ? 16'hA010 :
                    (r < 98) ? 16'h0000 : 16'($urandom);
            step(p);
            nchk++;
            if ({irq_req, tcb_busy, reset, viol_cnt} !== {e_irq, e_busy, e_rst, e_vc}) begin
                nfail++; $display("FAIL random t=%0d pc=%h: got %b%b%b/%0d required %b%b%b/%0d", t, p,
                                  irq_req, tcb_busy, reset, viol_cnt, e_irq, e_busy, e_rst, e_vc);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_deadline();
        test_bad_entry();
        test_bad_exit();
        test_collision();
        test_rst_mid();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
